// File: rtl/scope_pkg.sv
// Shared widths, colour type and screen limits for the oscilloscope display support blocks.
package scope_pkg;

   localparam int COORD_W  = 8;
   localparam int COLOR_W  = 12;
   localparam int SAMPLE_W = 8;

   typedef logic [COLOR_W-1:0] color_t;

   localparam color_t COLOR_BLACK = 12'h000;

   localparam int SCREEN_X_MAX = 159;
   localparam int SCREEN_Y_MAX = 119;

   function automatic logic coord_at_last(input logic [COORD_W-1:0] value,
                                          input logic [COORD_W-1:0] last);
      return (value == last);
   endfunction

endpackage

// File: rtl/scope_sample_ram.sv
// Simple dual-port sample memory with a registered, read-before-write read port.
module scope_sample_ram #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   // Storage array: no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read register samples the old contents on a same-address collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= {DATA_W{1'b0}};
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end else begin
         rd_data <= rd_data;
      end
   end

endmodule

// File: rtl/scope_clear_delay_ram.sv
// Display-sequencer support: full-screen clear scanner, wait timer and ADC sample RAM.
module scope_clear_delay_ram
   import scope_pkg::*;
#(
   parameter int     X_MAX        = SCREEN_X_MAX,
   parameter int     Y_MAX        = SCREEN_Y_MAX,
   parameter color_t CLEAR_COLOR  = COLOR_BLACK,
   parameter int     DELAY_CYCLES = 10008,
   parameter int     ADDR_W       = 8,
   parameter int     DATA_W       = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr_enable,
   input  logic               clr_reset,
   output logic [COORD_W-1:0] clr_x,
   output logic [COORD_W-1:0] clr_y,
   output logic [COLOR_W-1:0] clr_color,
   output logic               clr_finished,
   input  logic               dly_enable,
   input  logic               dly_reset,
   output logic               dly_finished,
   input  logic               wr_en,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [DATA_W-1:0]  wr_data,
   input  logic               rd_en,
   input  logic [ADDR_W-1:0]  rd_addr,
   output logic [DATA_W-1:0]  rd_data
);

   localparam int DLY_W = $clog2(DELAY_CYCLES + 1);
   localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(X_MAX);
   localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(Y_MAX);
   localparam logic [DLY_W-1:0]   DLY_LAST = DLY_W'(DELAY_CYCLES - 1);

   logic [DLY_W-1:0] dly_count;

   assign clr_color = CLEAR_COLOR;

   // Clear scanner: raster walk, one pixel per enabled cycle, parks at (0,0) when done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_x        <= {COORD_W{1'b0}};
         clr_y        <= {COORD_W{1'b0}};
         clr_finished <= 1'b0;
      end else if (clr_reset) begin
         clr_x        <= {COORD_W{1'b0}};
         clr_y        <= {COORD_W{1'b0}};
         clr_finished <= 1'b0;
      end else if (clr_finished || !clr_enable) begin
         clr_x        <= clr_x;
         clr_y        <= clr_y;
         clr_finished <= clr_finished;
      end else if (coord_at_last(clr_x, X_LAST)) begin
         clr_x <= {COORD_W{1'b0}};
         if (coord_at_last(clr_y, Y_LAST)) begin
            clr_y        <= {COORD_W{1'b0}};
            clr_finished <= 1'b1;
         end else begin
            clr_y        <= clr_y + 8'd1;
            clr_finished <= 1'b0;
         end
      end else begin
         clr_x        <= clr_x + 8'd1;
         clr_y        <= clr_y;
         clr_finished <= 1'b0;
      end
   end

   // Wait timer: finished latches on the DELAY_CYCLES-th enabled edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dly_count    <= {DLY_W{1'b0}};
         dly_finished <= 1'b0;
      end else if (dly_reset) begin
         dly_count    <= {DLY_W{1'b0}};
         dly_finished <= 1'b0;
      end else if (dly_finished || !dly_enable) begin
         dly_count    <= dly_count;
         dly_finished <= dly_finished;
      end else if (dly_count == DLY_LAST) begin
         dly_count    <= {DLY_W{1'b0}};
         dly_finished <= 1'b1;
      end else begin
         dly_count    <= dly_count + {{(DLY_W-1){1'b0}}, 1'b1};
         dly_finished <= 1'b0;
      end
   end

   scope_sample_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_sample_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_scope_clear_delay_ram.sv
// Randomized self-checking bench for scope_clear_delay_ram against an edge-count reference model.
module tb_scope_clear_delay_ram;

   localparam int XM    = 159;
   localparam int YM    = 119;
   localparam int TOTAL = (XM + 1) * (YM + 1);
   localparam int DLY   = 5;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clr_enable, clr_reset, dly_enable, dly_reset;
   logic       wr_en, rd_en;
   logic [7:0] wr_addr, wr_data, rd_addr;
   logic [7:0] clr_x, clr_y, rd_data;
   logic [11:0] clr_color;
   logic       clr_finished, dly_finished;

   int tests = 0;
   int fails = 0;

   // reference model state
   int         clr_n;
   int         dly_n;
   logic [7:0] ref_mem [256];
   bit         known [256];
   logic [7:0] exp_rd;
   bit         exp_known;

   scope_clear_delay_ram #(.DELAY_CYCLES(DLY)) dut (
      .clk(clk), .rst_n(rst_n),
      .clr_enable(clr_enable), .clr_reset(clr_reset),
      .clr_x(clr_x), .clr_y(clr_y), .clr_color(clr_color), .clr_finished(clr_finished),
      .dly_enable(dly_enable), .dly_reset(dly_reset), .dly_finished(dly_finished),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ex_x();
      return (clr_n >= TOTAL) ? 8'd0 : 8'(clr_n % (XM + 1));
   endfunction
   function automatic logic [7:0] ex_y();
      return (clr_n >= TOTAL) ? 8'd0 : 8'(clr_n / (XM + 1));
   endfunction
   function automatic logic ex_cf();
      return (clr_n >= TOTAL);
   endfunction
   function automatic logic ex_df();
      return (dly_n >= DLY);
   endfunction

   // one rising edge: model consumes the inputs seen at that edge, then wait for the falling edge
   task automatic tick();
      @(posedge clk);
      if (clr_reset) clr_n = 0;
      else if (clr_enable && clr_n < TOTAL) clr_n++;
      if (dly_reset) dly_n = 0;
      else if (dly_enable && dly_n < DLY) dly_n++;
      if (rd_en) begin
         exp_rd    = ref_mem[rd_addr];
         exp_known = known[rd_addr];
      end
      if (wr_en) begin
         ref_mem[wr_addr] = wr_data;
         known[wr_addr]   = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      clr_enable = 1'b0; clr_reset = 1'b0; dly_enable = 1'b0; dly_reset = 1'b0;
      wr_en = 1'b0; rd_en = 1'b0; wr_addr = 8'd0; wr_data = 8'd0; rd_addr = 8'd0;
   endtask

   task automatic random_inputs();
      clr_enable = 1'($urandom); clr_reset = ($urandom_range(0, 15) == 0);
      dly_enable = 1'($urandom); dly_reset = ($urandom_range(0, 7) == 0);
      wr_en = 1'($urandom); wr_addr = 8'($urandom); wr_data = 8'($urandom);
      rd_en = 1'($urandom); rd_addr = 8'($urandom);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      clr_n = 0; dly_n = 0; exp_rd = 8'd0; exp_known = 1'b1;
      for (int i = 0; i < 256; i++) known[i] = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         random_inputs();
         tick();
      end
      random_inputs();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      clr_n = 0; dly_n = 0; exp_rd = 8'd0; exp_known = 1'b1;
      tests++;
      if ({clr_x, clr_y, clr_finished, dly_finished, rd_data} !== {8'd0, 8'd0, 1'b0, 1'b0, 8'd0}) begin
         fails++;
         $display("FAIL reset: got x=%0d y=%0d cf=%b df=%b rd=%h, want all zero",
                  clr_x, clr_y, clr_finished, dly_finished, rd_data);
      end
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_clear_scan();
      tests++;
      if ({clr_x, clr_y, clr_finished} !== {8'd0, 8'd0, 1'b0}) begin
         fails++;
         $display("FAIL clear_start: got (%0d,%0d,%b) want (0,0,0)", clr_x, clr_y, clr_finished);
      end
      clr_enable = 1'b1;
      for (int i = 1; i <= TOTAL + 3; i++) begin
         tick();
         tests++;
         if ({clr_x, clr_y, clr_finished, clr_color} !== {ex_x(), ex_y(), ex_cf(), 12'h000}) begin
            fails++;
            $display("FAIL clear_scan edge %0d: got (%0d,%0d,%b,%h) want (%0d,%0d,%b,000)",
                     i, clr_x, clr_y, clr_finished, clr_color, ex_x(), ex_y(), ex_cf());
         end
      end
      tests++;
      if (clr_finished !== 1'b1) begin
         fails++;
         $display("FAIL clear_done: got finished=%b want 1", clr_finished);
      end
      clr_enable = 1'b0;
   endtask

   task automatic test_clear_pause();
      clr_reset = 1'b1; clr_enable = 1'b1;
      tick();
      clr_reset = 1'b0;
      tests++;
      if ({clr_x, clr_y, clr_finished} !== {8'd0, 8'd0, 1'b0}) begin
         fails++;
         $display("FAIL clear_restart: got (%0d,%0d,%b) want (0,0,0)", clr_x, clr_y, clr_finished);
      end
      repeat (5 * (XM + 1) + 37) tick();
      clr_enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         tests++;
         if ({clr_x, clr_y, clr_finished} !== {8'd37, 8'd5, 1'b0}) begin
            fails++;
            $display("FAIL clear_pause: got (%0d,%0d,%b) want (37,5,0)", clr_x, clr_y, clr_finished);
         end
      end
      clr_reset = 1'b1;
      tick();
      clr_reset = 1'b0;
      tests++;
      if ({clr_x, clr_y, clr_finished} !== {8'd0, 8'd0, 1'b0}) begin
         fails++;
         $display("FAIL clear_reset_pulse: got (%0d,%0d,%b) want (0,0,0)", clr_x, clr_y, clr_finished);
      end
   endtask

   task automatic test_delay();
      bit pattern [14] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
      dly_reset = 1'b1;
      tick();
      dly_reset = 1'b0;
      dly_enable = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         tests++;
         if (dly_finished !== (i >= DLY)) begin
            fails++;
            $display("FAIL delay_run edge %0d: got %b want %b", i, dly_finished, (i >= DLY));
         end
      end
      dly_reset = 1'b1;
      tick();
      dly_reset = 1'b0;
      tests++;
      if (dly_finished !== 1'b0) begin
         fails++;
         $display("FAIL delay_reset: got %b want 0", dly_finished);
      end
      // two enabled, three idle, then the remaining three enabled edges
      for (int i = 0; i < 14; i++) begin
         dly_enable = pattern[i];
         tick();
         tests++;
         if (dly_finished !== ex_df()) begin
            fails++;
            $display("FAIL delay_gap step %0d: got %b want %b", i, dly_finished, ex_df());
         end
      end
      tests++;
      if (dly_finished !== 1'b1) begin
         fails++;
         $display("FAIL delay_sticky: got %b want 1", dly_finished);
      end
      dly_enable = 1'b0;
      dly_reset = 1'b1;
      tick();
      dly_reset = 1'b0;
   endtask

   task automatic test_ram();
      idle_inputs();
      wr_en = 1'b1; wr_addr = 8'h10; wr_data = 8'hA5; tick();
      wr_addr = 8'hFF; wr_data = 8'h3C; tick();
      wr_en = 1'b0;
      rd_en = 1'b1; rd_addr = 8'h10; tick();
      tests++;
      if (rd_data !== 8'hA5) begin
         fails++;
         $display("FAIL ram_read_10: got %h want a5", rd_data);
      end
      rd_addr = 8'hFF; tick();
      tests++;
      if (rd_data !== 8'h3C) begin
         fails++;
         $display("FAIL ram_read_ff: got %h want 3c", rd_data);
      end
      rd_en = 1'b0; rd_addr = 8'h10;
      repeat (3) begin
         tick();
         tests++;
         if (rd_data !== 8'h3C) begin
            fails++;
            $display("FAIL ram_hold: got %h want 3c", rd_data);
         end
      end
      wr_en = 1'b1; wr_addr = 8'h20; wr_data = 8'h11; tick();
      wr_data = 8'h22; rd_en = 1'b1; rd_addr = 8'h20; tick();
      tests++;
      if (rd_data !== 8'h11) begin
         fails++;
         $display("FAIL ram_collision: got %h want 11", rd_data);
      end
      wr_en = 1'b0; tick();
      tests++;
      if (rd_data !== 8'h22) begin
         fails++;
         $display("FAIL ram_after_collision: got %h want 22", rd_data);
      end
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      idle_inputs();
      wr_en = 1'b1;
      for (int a = 0; a < 256; a++) begin
         wr_addr = 8'(a); wr_data = 8'($urandom);
         tick();
      end
      for (int i = 0; i < 3000; i++) begin
         random_inputs();
         tick();
         tests++;
         if ({clr_x, clr_y, clr_finished, dly_finished} !== {ex_x(), ex_y(), ex_cf(), ex_df()}) begin
            fails++;
            $display("FAIL mixed_engines cycle %0d: got (%0d,%0d,%b,%b) want (%0d,%0d,%b,%b)",
                     i, clr_x, clr_y, clr_finished, dly_finished, ex_x(), ex_y(), ex_cf(), ex_df());
         end
         if (exp_known) begin
            tests++;
            if (rd_data !== exp_rd) begin
               fails++;
               $display("FAIL mixed_ram cycle %0d: got %h want %h", i, rd_data, exp_rd);
            end
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_clear_scan();
      test_clear_pause();
      test_delay();
      test_ram();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
